// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer
// Iterative shift-add multiply unit with HI/LO result registers for the MIPS
// datapath. It runs MULT, MULTU, MADD and MSUB over WIDTH iteration cycles
// plus one accumulate cycle, and it handles single-cycle MTHI/MTLO writes.
//
// Ports:
//   Clk    rising-edge clock
//   Rst    asynchronous active-low reset
//   Start  request, sampled only in IDLE
//   Op     000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 11x reserved
//   A, B   operands rs / rt
//   Flush  synchronous abort of an in-flight multiply
//   Busy   high while a multiply is in flight (MUL and ACC states)
//   Done   one-cycle pulse when HI/LO hold the new result
//   HI, LO result registers
module hilo_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn_s;
  logic [2*WIDTH-1:0]   p_s;
  logic [2*WIDTH-1:0]   acc_s;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  // -2^(WIDTH-1) maps to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // Next-state and datapath computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sgn_s    = (Op != OP_MULTU);
    p_s      = neg_q ? -prod_q : prod_q;
    acc_s    = {hi_q, lo_q};

    case (state_q)
      S_IDLE: begin
        // Flush outranks Start while idle, so a coincident request is dropped.
        if (Flush) begin
          state_d = S_IDLE;
        end else if (Start) begin
          case (Op)
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              op_d     = Op;
              mcand_d  = {{WIDTH{1'b0}}, mag(A, sgn_s)};
              mplier_d = mag(B, sgn_s);
              neg_d    = sgn_s & (A[WIDTH-1] ^ B[WIDTH-1]);
              prod_d   = {(2*WIDTH){1'b0}};
              cnt_d    = {CW{1'b0}};
              state_d  = S_MUL;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end else begin
            prod_d = prod_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_ACC;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_ACC: begin
        // A coincident Flush wins over the write-back.
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          case (op_q)
            OP_MADD: acc_s = {hi_q, lo_q} + p_s;
            OP_MSUB: acc_s = {hi_q, lo_q} - p_s;
            default: acc_s = p_s;
          endcase
          {hi_d, lo_d} = acc_s;
          state_d      = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy = (state_q == S_MUL) || (state_q == S_ACC);
  assign Done = (state_q == S_DONE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
`timescale 1ns/100ps
// Directed bench for hilo_mult_sequencer with a HI/LO scoreboard.
module tb_hilo_mult_sequencer;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'b000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Flush = 1'b0;
  logic         Busy, Done;
  logic [W-1:0] HI, LO;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] model_hilo = 64'd0;
  logic [63:0] sb[$];

  hilo_mult_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, {32'd0, HI}, {32'd0, model_hilo[63:32]});
    check({tag, "_lo"}, {32'd0, LO}, {32'd0, model_hilo[31:0]});
  endtask

  // Reference product computed with native arithmetic, not shift-add.
  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb_v;
    if (op == 3'b001) begin
      return {32'd0, a} * {32'd0, b};
    end else begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      return 64'(sa * sb_v);
    end
  endfunction

  // MTHI/MTLO or reserved op from IDLE; completes in one cycle with no Busy.
  task automatic move_op(input logic [2:0] op, input logic [W-1:0] a, input logic flush);
    Start = 1'b1; Op = op; A = a; Flush = flush;
    if (!flush && op == 3'b100) model_hilo[63:32] = a;
    if (!flush && op == 3'b101) model_hilo[31:0] = a;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    check("move_busy", {63'd0, Busy}, 64'd0);
    check("move_done", {63'd0, Done}, 64'd0);
    check_hilo("move");
  endtask

  // Full multiply; optional injected Start (MTHI) at cycles inj1/inj2 (0 = none).
  task automatic run_mul(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj1, input int inj2);
    logic [63:0] p, e;
    p = ref_prod(op, a, b);
    case (op)
      3'b010:  model_hilo = model_hilo + p;
      3'b011:  model_hilo = model_hilo - p;
      default: model_hilo = p;
    endcase
    sb.push_back(model_hilo);
    Start = 1'b1; Op = op; A = a; B = b;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge Clk);
      check($sformatf("busy_c%0d", c), {63'd0, Busy}, {63'd0, (c <= W + 1)});
      check($sformatf("done_c%0d", c), {63'd0, Done}, {63'd0, (c == W + 2)});
      if (Done === 1'b1) begin
        check("sb_nonempty", {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_hi", {32'd0, HI}, {32'd0, e[63:32]});
          check("res_lo", {32'd0, LO}, {32'd0, e[31:0]});
        end
      end
      Start = (c == inj1) || (c == inj2);
      Op = Start ? 3'b100 : op;
      A  = Start ? 32'h1234_5678 : a;
    end
    check_hilo("post_idle");
  endtask

  // Multiply aborted by Flush (kind 0) or by reset pulse (kind 1) at cycle cyc.
  task automatic abort_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int kind, input int cyc);
    Start = 1'b1; Op = 3'b000; A = a; B = b;
    for (int c = 1; c <= cyc; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      check($sformatf("abort_busy_c%0d", c), {63'd0, Busy}, 64'd1);
    end
    if (kind == 0) begin
      Flush = 1'b1;
      @(negedge Clk);
      Flush = 1'b0;
      check("flush_busy", {63'd0, Busy}, 64'd0);
      check("flush_done", {63'd0, Done}, 64'd0);
      check_hilo("flush");
    end else begin
      #1 Rst = 1'b0;
      model_hilo = 64'd0;
      #1;
      check("rst_busy", {63'd0, Busy}, 64'd0);
      check("rst_done", {63'd0, Done}, 64'd0);
      check_hilo("rst");
      Rst = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("abort_quiet_busy", {63'd0, Busy}, 64'd0);
      check("abort_quiet_done", {63'd0, Done}, 64'd0);
    end
    check_hilo("abort_after");
  endtask

  initial begin
    // Reset state.
    #2;
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_done", {63'd0, Done}, 64'd0);
    check_hilo("reset");
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Signed and unsigned products, including the most-negative operand.
    run_mul(3'b000, 32'hFFFF_FFFD, 32'd5, 0, 0);
    run_mul(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_mul(3'b000, 32'h8000_0000, 32'h8000_0000, 0, 0);

    // Moves, then accumulate and subtract.
    move_op(3'b101, 32'd10, 1'b0);
    move_op(3'b100, 32'd0, 1'b0);
    run_mul(3'b010, 32'd2, 32'd3, 0, 0);
    run_mul(3'b011, 32'd4, 32'd5, 0, 0);

    // Reserved op and Flush-over-Start in IDLE are both no-ops.
    move_op(3'b110, 32'hDEAD_BEEF, 1'b0);
    move_op(3'b100, 32'hCAFE_F00D, 1'b1);

    // Start while busy (cycle 10) and in DONE (cycle W+2) is ignored.
    run_mul(3'b000, 32'd7, 32'd6, 10, W + 2);

    // Flush in MUL and in ACC leaves the preloaded HI/LO intact.
    move_op(3'b100, 32'd1, 1'b0);
    move_op(3'b101, 32'd2, 1'b0);
    abort_mul(32'd9, 32'd9, 0, 20);
    abort_mul(32'd9, 32'd9, 0, W + 1);

    // Asynchronous reset mid-operation, then a fresh multiply.
    abort_mul(32'd5, 32'd5, 1, 15);
    run_mul(3'b000, 32'd3, 32'd3, 0, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
